axi4_bram_read_arbiter: RTL and testbench

//  2:1 round-robin arbiter that shares the AXI4 read channels (AR + R) of one BRAM slave controller between two masters.

---
 rtl/axi4_bram_read_arbiter.sv | 145 ++++++++++++++
 tb/tb_axi4_bram_read_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_bram_read_arbiter.sv
// 2:1 round-robin arbiter sharing one BRAM controller's AXI4 read channels
// (AR + R) between two masters. A grant covers a whole burst. The final beat
// is recovered from a local beat count, so a burst still ends if the slave
// never raises RLAST.
module axi4_bram_read_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned AR_W   = 17 + ADDR_W,
  parameter int unsigned R_W    = 6 + DATA_W
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [2*AR_W-1:0]   M_ARPAYLOAD,
  input  logic [1:0]          M_ARVALID,
  output logic [1:0]          M_ARREADY,
  output logic [R_W-1:0]      M_RPAYLOAD,
  output logic [1:0]          M_RLAST,
  output logic [1:0]          M_RVALID,
  input  logic [1:0]          M_RREADY,
  output logic [AR_W-1:0]     S_ARPAYLOAD,
  output logic                S_ARVALID,
  input  logic                S_ARREADY,
  input  logic [R_W-1:0]      S_RPAYLOAD,
  input  logic                S_RLAST,
  input  logic                S_RVALID,
  output logic                S_RREADY,
  output logic                GRANT
);

  // ARLEN sits just above the 3-bit ARSIZE field in the AR payload
  localparam int unsigned LEN_LSB = 3;
  localparam int unsigned LEN_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               grant_q, grant_d;
  logic               prio_q,  prio_d;
  logic [LEN_W-1:0]   len_q,   len_d;
  logic [LEN_W-1:0]   beat_q,  beat_d;

  logic [AR_W-1:0]    ar_sel;
  logic               r_hs;
  logic               last_beat;

  // AR payload of the granted master
  always_comb begin
    ar_sel = M_ARPAYLOAD[AR_W-1:0];
    if (grant_q) begin
      ar_sel = M_ARPAYLOAD[2*AR_W-1:AR_W];
    end
  end

  // R handshake on the slave side and final-beat detection from the count
  always_comb begin
    r_hs      = (state_q == DATA) && S_RVALID && M_RREADY[grant_q];
    last_beat = (beat_q == len_q);
  end

  // Next-state: arbitration in IDLE, length capture in ADDR, beat counting in DATA
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    len_d   = len_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (|M_ARVALID) begin
          grant_d = M_ARVALID[prio_q] ? prio_q : ~prio_q;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (M_ARVALID[grant_q] && S_ARREADY) begin
          len_d   = ar_sel[LEN_LSB +: LEN_W];
          beat_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (r_hs) begin
          beat_d = beat_q + LEN_W'(1);
          // Whichever comes first: counted last beat or slave RLAST
          if (last_beat || S_RLAST) begin
            state_d = IDLE;
            prio_d  = ~grant_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake routing to the granted master; everything idles low outside its phase
  always_comb begin
    M_ARREADY   = '0;
    S_ARPAYLOAD = '0;
    S_ARVALID   = 1'b0;
    M_RVALID    = '0;
    M_RLAST     = '0;
    S_RREADY    = 1'b0;
    unique case (state_q)
      ADDR: begin
        S_ARPAYLOAD        = ar_sel;
        S_ARVALID          = M_ARVALID[grant_q];
        M_ARREADY[grant_q] = S_ARREADY;
      end
      DATA: begin
        M_RVALID[grant_q] = S_RVALID;
        M_RLAST[grant_q]  = S_RVALID && last_beat;
        S_RREADY          = M_RREADY[grant_q];
      end
      default: begin
      end
    endcase
  end

  assign M_RPAYLOAD = S_RPAYLOAD;
  assign GRANT      = grant_q;

  // State and arbitration registers with synchronous reset
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_axi4_bram_read_arbiter.sv
// Directed bench for axi4_bram_read_arbiter: drives both masters and the
// slave side cycle by cycle and checks routing, arbitration order and beat
// termination against hand-derived values.
module tb_axi4_bram_read_arbiter;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned AR_W   = 17 + ADDR_W;
  localparam int unsigned R_W    = 6 + DATA_W;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  logic               ACLK = 1'b0;
  logic               ARESET;
  logic [2*AR_W-1:0]  M_ARPAYLOAD;
  logic [1:0]         M_ARVALID;
  logic [1:0]         M_ARREADY;
  logic [R_W-1:0]     M_RPAYLOAD;
  logic [1:0]         M_RLAST;
  logic [1:0]         M_RVALID;
  logic [1:0]         M_RREADY;
  logic [AR_W-1:0]    S_ARPAYLOAD;
  logic               S_ARVALID;
  logic               S_ARREADY;
  logic [R_W-1:0]     S_RPAYLOAD;
  logic               S_RLAST;
  logic               S_RVALID;
  logic               S_RREADY;
  logic               GRANT;

  int n_chk  = 0;
  int n_pass = 0;

  axi4_bram_read_arbiter #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .M_ARPAYLOAD (M_ARPAYLOAD),
    .M_ARVALID   (M_ARVALID),
    .M_ARREADY   (M_ARREADY),
    .M_RPAYLOAD  (M_RPAYLOAD),
    .M_RLAST     (M_RLAST),
    .M_RVALID    (M_RVALID),
    .M_RREADY    (M_RREADY),
    .S_ARPAYLOAD (S_ARPAYLOAD),
    .S_ARVALID   (S_ARVALID),
    .S_ARREADY   (S_ARREADY),
    .S_RPAYLOAD  (S_RPAYLOAD),
    .S_RLAST     (S_RLAST),
    .S_RVALID    (S_RVALID),
    .S_RREADY    (S_RREADY),
    .GRANT       (GRANT)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [AR_W-1:0] mk_ar(input logic [3:0] id, input logic [4:0] a,
                                            input logic [1:0] b, input logic [7:0] l);
    return {id, a, b, l, 3'd0};
  endfunction

  // BRAM contents seen by the slave: word a holds A0+a
  function automatic logic [7:0] bram(input logic [4:0] a);
    return 8'hA0 + 8'(a);
  endfunction

  // One full burst for master m starting in IDLE; ends back in IDLE.
  // slave_last_at: beat index carrying S_RLAST (-1 = never).
  task automatic run_burst(input int m, input logic [3:0] id, input logic [4:0] addr,
                           input logic [1:0] burst, input logic [7:0] len,
                           input int slave_last_at, input int ar_wait, input bit throttle);
    logic [AR_W-1:0] p;
    logic [7:0]      d;
    logic [R_W-1:0]  rp;
    bit              rdy;
    int              k;
    int              c;
    int              endb;
    p = mk_ar(id, addr, burst, len);
    M_ARPAYLOAD[m*AR_W +: AR_W] = p;
    M_ARVALID[m] = 1'b1;
    S_ARREADY    = 1'b0;
    #1;
    chk("idle_arvalid",  32'(S_ARVALID), 32'd0);
    chk("idle_arpay",    32'(S_ARPAYLOAD), 32'd0);
    chk("idle_arready",  32'(M_ARREADY), 32'd0);
    tick();
    for (int w = 0; w < ar_wait; w++) begin
      chk("stall_arvalid", 32'(S_ARVALID), 32'd1);
      chk("stall_arpay",   32'(S_ARPAYLOAD), 32'(p));
      chk("stall_arready", 32'(M_ARREADY), 32'd0);
      chk("stall_grant",   32'(GRANT), 32'(m));
      tick();
    end
    S_ARREADY = 1'b1;
    #1;
    chk("addr_arvalid", 32'(S_ARVALID), 32'd1);
    chk("addr_arpay",   32'(S_ARPAYLOAD), 32'(p));
    chk("addr_arready", 32'(M_ARREADY), 32'(1) << m);
    chk("addr_grant",   32'(GRANT), 32'(m));
    tick();
    M_ARVALID[m] = 1'b0;
    S_ARREADY    = 1'b0;
    endb = (slave_last_at >= 0 && slave_last_at < int'(len)) ? slave_last_at : int'(len);
    k = 0;
    c = 0;
    while (k <= endb && c < 600) begin
      rdy         = throttle ? (c % 3 == 0) : 1'b1;
      M_RREADY    = 2'b11;
      M_RREADY[m] = rdy;
      d           = (burst == BURST_INCR) ? bram(addr + 5'(k)) : bram(addr);
      rp          = {id, d, 2'b00};
      S_RVALID    = 1'b1;
      S_RPAYLOAD  = rp;
      S_RLAST     = (k == slave_last_at);
      #1;
      chk("data_rvalid", 32'(M_RVALID), 32'(1) << m);
      chk("data_rready", 32'(S_RREADY), 32'(rdy));
      chk("data_rlast",  32'(M_RLAST), (k == int'(len)) ? (32'(1) << m) : 32'd0);
      chk("data_rpay",   32'(M_RPAYLOAD), 32'(rp));
      if (rdy) k++;
      c++;
      tick();
    end
    if (c >= 600) chk("beat_budget", 32'(c), 32'd0);
    // Slave keeps offering data: a finished burst must not pass it on
    S_RVALID = 1'b1;
    S_RLAST  = 1'b0;
    M_RREADY = 2'b11;
    #1;
    chk("end_rvalid", 32'(M_RVALID), 32'd0);
    chk("end_rready", 32'(S_RREADY), 32'd0);
    chk("end_rlast",  32'(M_RLAST), 32'd0);
    S_RVALID = 1'b0;
  endtask

  initial begin
    ARESET      = 1'b1;
    M_ARPAYLOAD = '0;
    M_ARVALID   = 2'b11;
    M_RREADY    = 2'b11;
    S_ARREADY   = 1'b1;
    S_RPAYLOAD  = '0;
    S_RLAST     = 1'b0;
    S_RVALID    = 1'b1;
    tick();
    tick();
    chk("rst_grant",   32'(GRANT), 32'd0);
    chk("rst_arready", 32'(M_ARREADY), 32'd0);
    chk("rst_arvalid", 32'(S_ARVALID), 32'd0);
    chk("rst_rvalid",  32'(M_RVALID), 32'd0);
    chk("rst_rlast",   32'(M_RLAST), 32'd0);
    chk("rst_rready",  32'(S_RREADY), 32'd0);
    M_ARVALID = 2'b00;
    S_ARREADY = 1'b0;
    S_RVALID  = 1'b0;
    tick();
    ARESET = 1'b0;
    tick();

    // Simultaneous requests after reset: M0 first, then M1 (single-beat ARLEN=0)
    M_ARPAYLOAD[AR_W +: AR_W] = mk_ar(4'h3, 5'd9, BURST_INCR, 8'd0);
    M_ARVALID[1] = 1'b1;
    run_burst(0, 4'h1, 5'd0, BURST_INCR, 8'd1, 1, 0, 1'b0);
    run_burst(1, 4'h3, 5'd9, BURST_INCR, 8'd0, 0, 0, 1'b0);

    // Second simultaneous pair: M0 again; M0 AR stalls 3 cycles while M1 waits
    M_ARPAYLOAD[AR_W +: AR_W] = mk_ar(4'h4, 5'd16, BURST_INCR, 8'd4);
    M_ARVALID[1] = 1'b1;
    run_burst(0, 4'h5, 5'd20, BURST_INCR, 8'd2, 2, 3, 1'b0);
    // M1 ARLEN=4 with RREADY pattern 1,0,0,...
    run_burst(1, 4'h4, 5'd16, BURST_INCR, 8'd4, 4, 0, 1'b1);

    // M0 alone, INCR from 2, four beats
    run_burst(0, 4'h1, 5'd2, BURST_INCR, 8'd3, 3, 0, 1'b0);
    // M0 FIXED, slave never raises RLAST
    run_burst(0, 4'h2, 5'd7, BURST_FIXED, 8'd2, -1, 0, 1'b0);
    // Slave RLAST on beat 1 of a 4-beat burst ends it early
    run_burst(0, 4'h6, 5'd1, BURST_INCR, 8'd3, 1, 0, 1'b0);

    // Reset during beat 2 of an ARLEN=5 burst
    M_ARPAYLOAD[AR_W-1:0] = mk_ar(4'h2, 5'd4, BURST_INCR, 8'd5);
    M_ARVALID = 2'b01;
    tick();
    S_ARREADY = 1'b1;
    tick();
    M_ARVALID = 2'b00;
    S_ARREADY = 1'b0;
    S_RVALID  = 1'b1;
    M_RREADY  = 2'b11;
    tick();
    tick();
    ARESET = 1'b1;
    #1;
    chk("pre_rst_rvalid", 32'(M_RVALID), 32'd1);
    tick();
    ARESET = 1'b0;
    #1;
    chk("mid_rst_rvalid",  32'(M_RVALID), 32'd0);
    chk("mid_rst_rready",  32'(S_RREADY), 32'd0);
    chk("mid_rst_rlast",   32'(M_RLAST), 32'd0);
    chk("mid_rst_grant",   32'(GRANT), 32'd0);
    chk("mid_rst_arvalid", 32'(S_ARVALID), 32'd0);
    S_RVALID = 1'b0;

    // Favoured master back to M0 after reset, then M1 served normally
    M_ARPAYLOAD[AR_W +: AR_W] = mk_ar(4'h7, 5'd3, BURST_INCR, 8'd1);
    M_ARVALID[1] = 1'b1;
    run_burst(0, 4'h8, 5'd5, BURST_INCR, 8'd0, 0, 0, 1'b0);
    run_burst(1, 4'h7, 5'd3, BURST_INCR, 8'd1, 1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
